fib_fifo_writer: RTL and testbench
==================================

# fib_fifo_writer

Producer stage that generates a Fibonacci sequence and pushes one term per accepted write into the downstream synchronous FIFO (`fifo_s`, 16-bit). It sits directly upstream of the FIFO. Its `wren`/`wdata` drive the FIFO write port, and it throttles on the FIFO `full` flag. Each run is launched by a `start` pulse and ends when the requested term count is written, the next term overflows `DATA_W`, or `abort` is asserted.

## Interface
- `DATA_W`, 16: term width; matches FIFO `wdata` width.
- `CNT_W`, 8: width of the term count and the written counter.
- `F0`, 0: first seed term.
- `F1`, 1: second seed term.

- `clk`  in  1  single clock, rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  1-cycle pulse; starts a run when idle.
- `n_terms`  in  CNT_W  number of terms requested; sampled on accepted `start`.
- `abort`  in  1  synchronous cancel of a running sequence.
- `full`  in  1  FIFO full flag.
- `wren`  out  1  FIFO write enable.
- `wdata`  out  DATA_W  term being written.
- `busy`  out  1  high while in RUN.
- `done`  out  1  1-cycle pulse at end of every run.
- `ovf`  out  1  sticky; the run stopped on overflow. Cleared by the next accepted `start`.
- `terms_written`  out  CNT_W  writes accepted in the current or last run. Cleared on accepted `start`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE on any of three events: `terms_written == n_terms`, overflow of the pending term, or `abort`.
  - DONE -> IDLE unconditionally after 1 cycle.
- Internal registers: `a` and `b` (DATA_W each), with overflow tags `a_ovf` and `b_ovf`.
- On accepted `start`:
  - `a <= F0`, `b <= F1`, both tags cleared.
  - `n_terms` is latched.
  - `terms_written <= 0`, `ovf <= 0`.
- `wdata = a`, combinational from the register.
- `wren = (state==RUN) & ~full & ~abort & ~a_ovf & (terms_written != n_lat)`.
- On each edge with `wren=1`:
  - `a <= b`, `a_ovf <= b_ovf`.
  - `b <= (a+b)[DATA_W-1:0]`.
  - `b_ovf <= carry(a+b) | a_ovf | b_ovf`. The sum is computed at DATA_W+1 bits.
  - `terms_written` increments.
- Overflow: in RUN with `a_ovf=1` and `terms_written != n_lat`, no write occurs. The block sets `ovf <= 1` and goes to DONE.
- `n_terms == 0`: RUN -> DONE on the first RUN cycle with no write.
- `start` is ignored outside IDLE.
- `abort` is ignored outside RUN.
- When `abort` and `full` are asserted together, `abort` wins.
- `full` high stalls the sequence. No term is skipped or duplicated.

## Timing
- Reset values (asynchronous, immediate):
  - `wren=0`, `wdata=F0` (`a=F0`), `busy=0`, `done=0`, `ovf=0`, `terms_written=0`.
  - State = IDLE.
- Start latency: `start` is sampled at edge k. RUN and `busy` begin in cycle k+1, and the first `wren` can occur in cycle k+1.
- Throughput: 1 term per cycle while `full=0`.
- The last write is at edge m. `done` is high during cycle m+2 (RUN evaluates completion in cycle m+1, then DONE).
- On `abort` in cycle j, `done` is high in cycle j+1 and there is no write at edge j.
- Reset mid-run aborts the run. `done` does not pulse. The FIFO keeps the terms already written.
- With DATA_W=16, F0=0, F1=1, terms F(0)..F(24) fit; F(24)=46368. F(25)=75025 overflows.

## Test plan
- `n_terms=10`, `full=0`: `wren` is high for 10 consecutive cycles starting the cycle after `start`. `wdata` = 0,1,1,2,3,5,8,13,21,34. `done` pulses once, `terms_written=10`, `ovf=0`. FIFO reads return the same order.
- `n_terms=30`: exactly 25 writes occur, the last with `wdata=46368`. Then `ovf=1`, `terms_written=25`, `done` pulses once.
- `n_terms=8` with `full` forced high for 4 cycles after the 3rd write: `wren` is low during those cycles. After release the writes are 2,3,5,8,13 with no gap or duplicate in the sequence.
- `n_terms=0`: no `wren`. `done` pulses 2 cycles after `start`, `terms_written=0`.
- `abort` after the 4th write, with a second `start` pulsed during RUN: writes are 0,1,1,2 only, `done` pulses once, `terms_written=4`. The mid-run `start` has no effect.
- `arst_n` low mid-run after 5 writes: outputs go to reset values immediately with no `done`. A new `start` after release restarts the sequence at 0,1,1.

Source files
------------

// File: rtl/fib_fifo_writer.sv
// Fibonacci producer feeding a downstream synchronous FIFO write port.
// One term is pushed per accepted write; a run ends on term count, overflow or abort.
module fib_fifo_writer #(
  parameter int                DATA_W = 16,
  parameter int                CNT_W  = 8,
  parameter logic [DATA_W-1:0] F0     = '0,
  parameter logic [DATA_W-1:0] F1     = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic              abort,
  input  logic              full,
  output logic              wren,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [CNT_W-1:0]  terms_written
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] a, b;
  logic              a_ovf, b_ovf;
  logic [CNT_W-1:0]  n_lat;
  logic [DATA_W:0]   sum;
  logic              start_acc;
  logic              count_hit;
  logic              ovf_hit;

  // The carry out of the extra sum bit marks a term that no longer fits DATA_W.
  assign sum       = {1'b0, a} + {1'b0, b};
  assign start_acc = (state == IDLE) && start;
  assign count_hit = (terms_written == n_lat);
  assign ovf_hit   = (state == RUN) && a_ovf && !count_hit;
  assign wdata     = a;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort || count_hit || a_ovf) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    wren = 1'b0;
    case (state)
      RUN: begin
        busy = 1'b1;
        wren = !full && !abort && !a_ovf && !count_hit;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Terms only advance on an accepted write, so a stall never skips or repeats a term.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a             <= F0;
      b             <= F1;
      a_ovf         <= 1'b0;
      b_ovf         <= 1'b0;
      n_lat         <= '0;
      terms_written <= '0;
      ovf           <= 1'b0;
    end else if (start_acc) begin
      a             <= F0;
      b             <= F1;
      a_ovf         <= 1'b0;
      b_ovf         <= 1'b0;
      n_lat         <= n_terms;
      terms_written <= '0;
      ovf           <= 1'b0;
    end else begin
      if (wren) begin
        a             <= b;
        a_ovf         <= b_ovf;
        b             <= sum[DATA_W-1:0];
        b_ovf         <= sum[DATA_W] | a_ovf | b_ovf;
        terms_written <= terms_written + CNT_W'(1);
      end
      if (ovf_hit) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fib_fifo_writer.sv
// Randomized scoreboard bench for fib_fifo_writer: stimulus queues expected
// terms and run outcomes, a negedge monitor checks every write and every done.
module tb_fib_fifo_writer;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              arst_n;
  logic              start;
  logic [CNT_W-1:0]  n_terms;
  logic              abort;
  logic              full;
  logic              wren;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [CNT_W-1:0]  terms_written;

  fib_fifo_writer #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W),
    .F0    (16'd0),
    .F1    (16'd1)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .start        (start),
    .n_terms      (n_terms),
    .abort        (abort),
    .full         (full),
    .wren         (wren),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf),
    .terms_written(terms_written)
  );

  typedef struct {
    int exp_count;
    bit exp_ovf;
    int start_cyc;
    int full_mode;
    int abort_at;
  } run_t;

  run_t    run_q[$];
  longint  exp_q[$];
  int      n_checks    = 0;
  int      n_fail      = 0;
  int      cyc         = 0;
  int      writes_in_run = 0;
  int      last_wr_cyc = -1;
  int      abort_cyc   = -1;
  int      done_count  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares each presented write and each completion against the queues.
  always @(negedge clk) begin
    run_t r;
    longint e;
    int ref_cyc;
    if (!arst_n) begin
      exp_q.delete();
      run_q.delete();
      writes_in_run = 0;
      last_wr_cyc   = -1;
      abort_cyc     = -1;
    end else begin
      if (busy && abort && abort_cyc < 0) abort_cyc = cyc;
      if (wren) begin
        checkOutput("wren_gated_by_full_abort", {full, abort}, 0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wdata", wdata, e);
        end
        if (run_q.size() > 0 && run_q[0].full_mode == 0)
          checkOutput("write_cycle", cyc, run_q[0].start_cyc + 1 + writes_in_run);
        last_wr_cyc = cyc;
        writes_in_run++;
      end
      if (done) begin
        if (run_q.size() == 0) begin
          checkOutput("spurious_done", 1, 0);
        end else begin
          r = run_q.pop_front();
          checkOutput("terms_written", terms_written, r.exp_count);
          checkOutput("write_count", writes_in_run, r.exp_count);
          checkOutput("ovf", ovf, r.exp_ovf);
          checkOutput("leftover_terms", exp_q.size(), 0);
          if (r.abort_at >= 0) ref_cyc = abort_cyc + 1;
          else if (writes_in_run > 0) ref_cyc = last_wr_cyc + 2;
          else ref_cyc = r.start_cyc + 2;
          checkOutput("done_latency", cyc, ref_cyc);
        end
        done_count++;
        writes_in_run = 0;
        last_wr_cyc   = -1;
        abort_cyc     = -1;
      end
    end
  end

  // Reference: Fibonacci terms F0=0,F1=1 that fit 16 bits, limited to n.
  function automatic int fibCount(input int n);
    longint x = 0, y = 1, t;
    int cnt = 0;
    while (cnt < n && x < 65536) begin
      cnt++;
      t = x + y; x = y; y = t;
    end
    return cnt;
  endfunction

  function automatic longint fibTerm(input int i);
    longint x = 0, y = 1, t;
    for (int k = 0; k < i; k++) begin
      t = x + y; x = y; y = t;
    end
    return x;
  endfunction

  // abort_req: -1 none, -2 random, >=0 abort once that many writes have landed.
  task automatic applyStimulus(input int n, input int abort_req, input int full_mode, input bit mid_start);
    run_t r;
    int total, d0, stall;
    bit finished, abort_sent;
    total = fibCount(n);
    r.abort_at = abort_req;
    if (abort_req == -2) r.abort_at = (total > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
    r.exp_count = (r.abort_at >= 0) ? r.abort_at : total;
    r.exp_ovf   = (r.abort_at < 0) && (total < n);
    r.start_cyc = cyc;
    r.full_mode = full_mode;
    for (int i = 0; i < r.exp_count; i++) exp_q.push_back(fibTerm(i));
    run_q.push_back(r);
    d0 = done_count;
    stall = 0;
    finished = 0;
    abort_sent = 0;
    start   = 1'b1;
    n_terms = CNT_W'(n);
    for (int c = 0; c < 600 && !finished; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      full  = 1'b0;
      if (c == 0) begin
        checkOutput("busy_after_start", busy, 1);
        checkOutput("count_cleared_on_start", terms_written, 0);
        checkOutput("ovf_cleared_on_start", ovf, 0);
      end
      if (done_count != d0) begin
        finished = 1;
      end else begin
        if (full_mode == 1) full = ($urandom_range(0, 3) == 0);
        if (full_mode == 2 && writes_in_run == 3 && stall < 4) begin
          full = 1'b1;
          stall++;
        end
        if (r.abort_at >= 0 && !abort_sent && writes_in_run == r.abort_at) begin
          abort = 1'b1;
          abort_sent = 1;
        end
        if (mid_start && c == 2) begin
          start   = 1'b1;
          n_terms = 8'd99;
        end
      end
    end
    if (!finished) begin
      checkOutput("done_timeout", 1, 0);
      arst_n = 1'b0;
      @(posedge clk); #1;
      arst_n = 1'b1;
    end
    full  = 1'b0;
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int d0;
    bit reached;
    arst_n  = 1'b0;
    start   = 1'b0;
    n_terms = '0;
    abort   = 1'b0;
    full    = 1'b0;
    #2;
    checkOutput("reset_wren", wren, 0);
    checkOutput("reset_wdata", wdata, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_terms_written", terms_written, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(10, -1, 0, 0);
    applyStimulus(30, -1, 0, 0);
    applyStimulus(8,  -1, 2, 0);
    applyStimulus(0,  -1, 0, 0);
    applyStimulus(10,  4, 0, 1);
    applyStimulus(25, -1, 0, 0);
    applyStimulus(26, -1, 1, 0);
    applyStimulus(5,   0, 0, 0);

    // Reset in the middle of a run must drop it silently.
    exp_q.push_back(0);
    run_q.push_back('{exp_count: 20, exp_ovf: 0, start_cyc: cyc, full_mode: 0, abort_at: -1});
    for (int i = 1; i < 20; i++) exp_q.push_back(fibTerm(i));
    d0 = done_count;
    start   = 1'b1;
    n_terms = 8'd20;
    @(posedge clk); #1;
    start = 1'b0;
    reached = 0;
    for (int c = 0; c < 50 && !reached; c++) begin
      if (writes_in_run == 5) reached = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("reached_5_writes", reached, 1);
    arst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_wren", wren, 0);
    checkOutput("midrun_reset_wdata", wdata, 0);
    checkOutput("midrun_reset_busy", busy, 0);
    checkOutput("midrun_reset_done", done, 0);
    checkOutput("midrun_reset_terms", terms_written, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_n = 1'b1;
    checkOutput("no_done_on_reset", done_count, d0);
    @(posedge clk); #1;
    applyStimulus(3, -1, 0, 0);

    for (int i = 0; i < 14; i++)
      applyStimulus(int'($urandom_range(0, 40)), -2, int'($urandom_range(0, 2)), 0);

    checkOutput("scoreboard_empty", exp_q.size() + run_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
